// File: rtl/rrq_pkg.sv
// rrq_pkg: shared constants and types for the rr_req_queue4 request queue.
//   N_CH    : channel count, fixed to the downstream arbiter width
//   CNT_W   : width of each per-channel pending counter
//   CNT_MAX : saturation value of a pending counter
//   cnt_t   : pending-counter type
package rrq_pkg;

  localparam int unsigned N_CH  = 4;
  localparam int unsigned CNT_W = 3;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_MAX = '1;

endpackage

// File: rtl/rrq_chan.sv
// rrq_chan: one channel of the request queue. Counts request rising edges,
// retires one request per grant, and drives the per-channel arbiter request.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   rise       : a new request arrives this cycle
//   gnt_bit    : the arbiter's registered grant for this channel
//   cnt        : pending request count (saturating)
//   req_bit    : request to the arbiter
//   ovf_set    : pulse, a request was dropped because the counter was full
//   err_set    : pulse, a grant arrived while nothing was pending
module rrq_chan
  import rrq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rise,
  input  logic             gnt_bit,
  output logic [CNT_W-1:0] cnt,
  output logic             req_bit,
  output logic             ovf_set,
  output logic             err_set
);

  cnt_t cnt_q, cnt_d;

  always_comb begin
    cnt_d   = cnt_q;
    ovf_set = 1'b0;
    err_set = 1'b0;
    if (rise && gnt_bit) begin
      // A grant against an empty counter is spurious, but the new request
      // still has to be recorded.
      if (cnt_q == '0) begin
        cnt_d   = cnt_t'(1);
        err_set = 1'b1;
      end
    end else if (rise) begin
      if (cnt_q == CNT_MAX) ovf_set = 1'b1;
      else                  cnt_d   = cnt_q + cnt_t'(1);
    end else if (gnt_bit) begin
      if (cnt_q == '0) err_set = 1'b1;
      else             cnt_d   = cnt_q - cnt_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
  // The grant visible this cycle already retires one request, so the last
  // pending request is masked to keep the arbiter from granting it twice.
  assign req_bit = (cnt_q > cnt_t'(gnt_bit));

endmodule

// File: rtl/rr_req_queue4.sv
// rr_req_queue4: request-conditioning stage in front of a 4-way round-robin
// arbiter. Each rising edge of a raw request line becomes one pending request;
// req[i] stays high while channel i has ungranted requests.
// Optional feature macro: RRQ_SYNC_EN -- adds a 2-flop synchronizer on each
// req_in bit ahead of edge detection (all latencies grow by 2 clocks).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req_in     : raw request lines, a 0->1 transition is one request
//   gnt        : one-hot registered grant from the arbiter
//   clr_ovf    : synchronous clear of ovf and gnt_err
//   req        : request vector to the arbiter
//   pend       : per-channel pending counts {cnt3,cnt2,cnt1,cnt0}
//   ovf        : sticky, a request was dropped at saturation
//   gnt_err    : sticky, a grant arrived for a channel with nothing pending
module rr_req_queue4
  import rrq_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       req_in,
  input  logic [N_CH-1:0]       gnt,
  input  logic                  clr_ovf,
  output logic [N_CH-1:0]       req,
  output logic [N_CH*CNT_W-1:0] pend,
  output logic [N_CH-1:0]       ovf,
  output logic                  gnt_err
);

  logic [N_CH-1:0] s;
  logic [N_CH-1:0] prev_q;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] ovf_set, err_set;
  logic [N_CH-1:0] ovf_q, ovf_d;
  logic            err_q, err_d;

`ifdef RRQ_SYNC_EN
  logic [N_CH-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= req_in;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;
`else
  assign s = req_in;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= '0;
    else        prev_q <= s;
  end

  assign rise = s & ~prev_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    rrq_chan u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .rise    (rise[i]),
      .gnt_bit (gnt[i]),
      .cnt     (pend[i*CNT_W +: CNT_W]),
      .req_bit (req[i]),
      .ovf_set (ovf_set[i]),
      .err_set (err_set[i])
    );
  end

  // A set in the same cycle as the clear wins.
  always_comb begin
    ovf_d = (clr_ovf ? '0 : ovf_q) | ovf_set;
    err_d = (clr_ovf ? 1'b0 : err_q) | (|err_set);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= '0;
      err_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      err_q <= err_d;
    end
  end

  assign ovf     = ovf_q;
  assign gnt_err = err_q;

endmodule

// File: tb/tb_rr_req_queue4.sv
module tb_rr_req_queue4;
  import rrq_pkg::*;

`ifdef RRQ_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_in = '0;
  logic [3:0]  gnt = '0;
  logic        clr_ovf = 1'b0;
  logic [3:0]  req;
  logic [11:0] pend;
  logic [3:0]  ovf;
  logic        gnt_err;

  always #5 clk = ~clk;

  rr_req_queue4 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_in  (req_in),
    .gnt     (gnt),
    .clr_ovf (clr_ovf),
    .req     (req),
    .pend    (pend),
    .ovf     (ovf),
    .gnt_err (gnt_err)
  );

  // Reference model: pending count = requests seen - valid grants, capped.
  int         m_cnt [4] = '{0, 0, 0, 0};
  logic [3:0] m_prev = '0, m_s1 = '0, m_s2 = '0, m_ovf = '0;
  logic       m_err = 1'b0;

  int passed = 0;
  int total  = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk or negedge rst_n) begin : model
    logic [3:0] sv, ovf_n;
    logic       err_n;
    int         r, g, n;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) m_cnt[i] <= 0;
      m_prev <= '0; m_s1 <= '0; m_s2 <= '0; m_ovf <= '0; m_err <= 1'b0;
    end else begin
`ifdef RRQ_SYNC_EN
      sv = m_s2;
`else
      sv = req_in;
`endif
      ovf_n = clr_ovf ? 4'b0 : m_ovf;
      err_n = clr_ovf ? 1'b0 : m_err;
      for (int i = 0; i < 4; i++) begin
        r = (sv[i] && !m_prev[i]) ? 1 : 0;
        g = gnt[i] ? 1 : 0;
        if (g == 1 && m_cnt[i] == 0) begin
          err_n = 1'b1;   // grant with nothing pending retires nothing
          g = 0;
        end
        n = m_cnt[i] + r - g;
        if (n > 7) begin
          n = 7;
          ovf_n[i] = 1'b1;
        end
        m_cnt[i] <= n;
      end
      m_s1 <= req_in; m_s2 <= m_s1; m_prev <= sv;
      m_ovf <= ovf_n; m_err <= err_n;
    end
  end

  always @(negedge clk) begin : compare
    logic [3:0]  e_req;
    logic [11:0] e_pend;
    if (chk_en) begin
      for (int i = 0; i < 4; i++) begin
        e_req[i] = (m_cnt[i] > (gnt[i] ? 1 : 0));
        e_pend[i*3 +: 3] = 3'(m_cnt[i]);
      end
      chk("cyc_req", 12'(req), 12'(e_req));
      chk("cyc_pend", pend, e_pend);
      chk("cyc_ovf", 12'(ovf), 12'(m_ovf));
      chk("cyc_gnt_err", 12'(gnt_err), 12'(m_err));
    end
  end

  task automatic tick(input logic [3:0] r, input logic [3:0] g, input logic c);
    @(posedge clk);
    #1;
    req_in = r; gnt = g; clr_ovf = c;
    #1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] g;
    int         k, st;
    // 1: reset with requests high
    rst_n = 1'b0; req_in = 4'hF;
    @(posedge clk); #2;
    chk_en = 1;
    chk("rst_req", 12'(req), 12'd0);
    chk("rst_pend", pend, 12'd0);
    chk("rst_ovf", 12'(ovf), 12'd0);
    chk("rst_gnt_err", 12'(gnt_err), 12'd0);
    req_in = 4'h0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (LAT + 2) tick(4'h0, 4'h0, 1'b0);

    // 2: single request on ch2, granted one cycle after req rises
    tick(4'b0100, 4'h0, 1'b0);
    repeat (LAT) tick(4'h0, 4'h0, 1'b0);
    tick(4'h0, 4'h0, 1'b0);
    chk("t2_pend_1", 12'(pend[8:6]), 12'd1);
    chk("t2_model_1", 12'(m_cnt[2]), 12'd1);
    chk("t2_req_hi", 12'(req[2]), 12'd1);
    tick(4'h0, 4'b0100, 1'b0);
    chk("t2_req_masked", 12'(req[2]), 12'd0);
    tick(4'h0, 4'h0, 1'b0);
    chk("t2_pend_0", 12'(pend[8:6]), 12'd0);
    chk("t2_gnt_err", 12'(gnt_err), 12'd0);

    // 3: three requests on ch0, then three grants
    repeat (3) begin
      tick(4'b0001, 4'h0, 1'b0);
      tick(4'h0, 4'h0, 1'b0);
    end
    repeat (LAT) tick(4'h0, 4'h0, 1'b0);
    chk("t3_pend_3", 12'(pend[2:0]), 12'd3);
    chk("t3_req_hi", 12'(req[0]), 12'd1);
    tick(4'h0, 4'b0001, 1'b0);
    chk("t3_g1_req", 12'(req[0]), 12'd1);
    tick(4'h0, 4'b0001, 1'b0);
    chk("t3_pend_2", 12'(pend[2:0]), 12'd2);
    tick(4'h0, 4'b0001, 1'b0);
    chk("t3_pend_1", 12'(pend[2:0]), 12'd1);
    chk("t3_req_drop", 12'(req[0]), 12'd0);
    tick(4'h0, 4'h0, 1'b0);
    chk("t3_pend_0", 12'(pend[2:0]), 12'd0);

    // 4: rise and grant on ch1 in the same cycle with cnt=2
    repeat (2) begin
      tick(4'b0010, 4'h0, 1'b0);
      tick(4'h0, 4'h0, 1'b0);
    end
    repeat (LAT) tick(4'h0, 4'h0, 1'b0);
    chk("t4_pend_2", 12'(pend[5:3]), 12'd2);
    repeat (LAT) tick(4'b0010, 4'h0, 1'b0);
    tick(4'b0010, 4'b0010, 1'b0);
    chk("t4_req_gnt", 12'(req[1]), 12'd1);
    tick(4'h0, 4'h0, 1'b0);
    chk("t4_pend_hold", 12'(pend[5:3]), 12'd2);
    chk("t4_req_hold", 12'(req[1]), 12'd1);
    tick(4'h0, 4'b0010, 1'b0);
    tick(4'h0, 4'b0010, 1'b0);
    tick(4'h0, 4'h0, 1'b0);
    chk("t4_drained", 12'(pend[5:3]), 12'd0);

    // 5: ch3 saturation and ovf clear
    repeat (8) begin
      tick(4'b1000, 4'h0, 1'b0);
      tick(4'h0, 4'h0, 1'b0);
    end
    repeat (LAT) tick(4'h0, 4'h0, 1'b0);
    chk("t5_pend_max", 12'(pend[11:9]), 12'd7);
    chk("t5_ovf_set", 12'(ovf), 12'b1000);
    tick(4'h0, 4'h0, 1'b1);
    chk("t5_ovf_before_clr", 12'(ovf[3]), 12'd1);
    tick(4'h0, 4'h0, 1'b0);
    chk("t5_ovf_clr", 12'(ovf), 12'd0);
    repeat (7) tick(4'h0, 4'b1000, 1'b0);
    tick(4'h0, 4'h0, 1'b0);
    chk("t5_drained", pend, 12'd0);

    // 6: grant with nothing pending
    tick(4'h0, 4'b0001, 1'b0);
    chk("t6_req0", 12'(req[0]), 12'd0);
    tick(4'h0, 4'h0, 1'b0);
    chk("t6_gnt_err", 12'(gnt_err), 12'd1);
    chk("t6_pend0", 12'(pend[2:0]), 12'd0);
    tick(4'h0, 4'h0, 1'b1);
    tick(4'h0, 4'h0, 1'b0);
    chk("t6_err_clr", 12'(gnt_err), 12'd0);

    // Random traffic: mostly arbiter-like grants, occasional spurious ones
    for (int c = 0; c < 600; c++) begin
      k = $urandom_range(0, 9);
      g = 4'h0;
      if (k < 6) begin
        st = $urandom_range(0, 3);
        for (int j = 0; j < 4; j++)
          if (g == 4'h0 && m_cnt[(st + j) % 4] > 0) g[(st + j) % 4] = 1'b1;
      end else if (k >= 8) begin
        g[$urandom_range(0, 3)] = 1'b1;
      end
      tick(4'($urandom & $urandom), g, ($urandom_range(0, 31) == 0));
    end
    tick(4'h0, 4'h0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
